// File: rtl/tnbuf_pkg.sv
// Shared types and helpers for the tristate bus driver controller.
package tnbuf_pkg;

    // Controller states: no owner, one channel driving, dead-time hand-over.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    // Width of a counter that must hold values 0..n. Never returns 0, so a
    // disabled limit (n = 0) still yields a legal one-bit vector.
    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tnbuf_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module tnbuf_rr_pick #(
    parameter int NCH = 4,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] pick,
    output logic [IW-1:0]  idx,
    output logic           valid
);

    // Scan NCH positions starting at ptr; the first hit wins.
    always_comb begin
        int c;
        c     = 0;
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            c = (int'(ptr) + k) % NCH;
            if (!valid && req[c]) begin
                valid   = 1'b1;
                idx     = IW'(c);
                pick[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tnbuf_bus_ctrl.sv
// Multi-channel tristate bus controller: round-robin grant, break-before-make
// dead time between owners, optional hold limit forcing a hand-over.
module tnbuf_bus_ctrl
    import tnbuf_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NCH     = 4,
    parameter int DEAD    = 1,
    parameter int MAXHOLD = 0
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [NCH-1:0]            req,
    input  logic [NCH*WIDTH-1:0]      inp,
    output logic [NCH-1:0]            gnt,
    output logic [NCH-1:0]            enb,
    output logic [WIDTH-1:0]          z,
    output logic [$clog2(NCH)-1:0]    owner,
    output logic                      busy
);

    localparam int IW = $clog2(NCH);
    localparam int HW = cnt_w(MAXHOLD);
    localparam int DW = cnt_w(DEAD);

    state_t          state_reg;
    logic [IW-1:0]   ptr_reg;
    logic [HW-1:0]   hold_cnt_reg;
    logic [DW-1:0]   dead_cnt_reg;

    logic [NCH-1:0]  pick_oh;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;
    logic [IW-1:0]   pick_next;
    logic            preempt;
    logic            dead_last;

    logic [WIDTH-1:0] slice [NCH];

    tnbuf_rr_pick #(
        .NCH (NCH),
        .IW  (IW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .pick  (pick_oh),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Search for the next arbitration starts just past the winner.
    assign pick_next = (pick_idx == IW'(NCH - 1)) ? '0 : pick_idx + IW'(1);

    // Hold limit reached while someone else is waiting.
    assign preempt = (MAXHOLD != 0) && (hold_cnt_reg == HW'(MAXHOLD - 1))
                     && |(req & ~gnt);

    assign dead_last = (dead_cnt_reg == DW'(DEAD - 1));

    // Single FSM register block; grant, owner and busy are registered here.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg    <= S_IDLE;
            gnt          <= '0;
            owner        <= '0;
            busy         <= 1'b0;
            ptr_reg      <= '0;
            hold_cnt_reg <= '0;
            dead_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_reg    <= S_DRIVE;
                        gnt          <= pick_oh;
                        owner        <= pick_idx;
                        ptr_reg      <= pick_next;
                        hold_cnt_reg <= '0;
                        busy         <= 1'b1;
                    end
                end
                S_DRIVE: begin
                    if (!req[owner] || preempt) begin
                        state_reg    <= S_TURN;
                        gnt          <= '0;
                        dead_cnt_reg <= '0;
                    end else if ((MAXHOLD != 0) && (hold_cnt_reg != HW'(MAXHOLD))) begin
                        hold_cnt_reg <= hold_cnt_reg + HW'(1);
                    end
                end
                S_TURN: begin
                    if (dead_last) begin
                        if (pick_valid) begin
                            state_reg    <= S_DRIVE;
                            gnt          <= pick_oh;
                            owner        <= pick_idx;
                            ptr_reg      <= pick_next;
                            hold_cnt_reg <= '0;
                        end else begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        dead_cnt_reg <= dead_cnt_reg + DW'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    gnt       <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Enables are the grant register itself, so they follow reset instantly.
    assign enb = gnt;

    // Unpack the channel data into an indexable array.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_slice
            assign slice[gi] = inp[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Owner's data straight onto the bus; released whenever no enable is high.
    assign z = (|enb) ? slice[owner] : {WIDTH{1'bz}};

endmodule
